window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Consumer end of the two-tap line buffer (shift_register_2taps) in the image pipeline.
- Takes one aligned column of three vertically adjacent pixels per valid beat: current row plus the two line-delayed taps.
- Tracks raster position, holds a 3x3 sliding window and flags when that window is fully inside the frame.
- Drives 3x3 kernels (Sobel, median, Gaussian) downstream.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line; must match line buffer depth; minimum 3.
- IMG_HEIGHT, 480, lines per frame; minimum 3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- pix_valid  input  1  column beat valid; same strobe as line buffer shiftin_valid.
- row2_in  input  DATA_WIDTH  newest row pixel (line buffer shiftin).
- row1_in  input  DATA_WIDTH  one-line-delayed pixel (taps1x).
- row0_in  input  DATA_WIDTH  two-line-delayed pixel (taps0x).
- win_data  output  9*DATA_WIDTH  window; element (r,c) at bits [(3r+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 top/oldest line, c=0 left/oldest column.
- win_valid  output  1  win_data holds a complete in-frame window.
- win_col  output  $clog2(IMG_WIDTH)  center column of the window.
- win_row  output  $clog2(IMG_HEIGHT)  center row of the window.
- frame_done  output  1  one-cycle pulse with the last window of the frame.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - win_data = 0, win_valid = 0, win_col = 0, win_row = 0, frame_done = 0.
  - col_cnt = 0, row_cnt = 0, state = FILL.
  - Reset mid-frame discards the partial frame. The next pix_valid is treated as pixel (0,0).
- Alignment:
  - The three inputs are column-aligned in the same cycle as pix_valid.
  - No internal delay compensation.
- On each pix_valid=1:
  - Shift the window left one column: column c takes column c+1.
  - Load column 2 with {row0_in, row1_in, row2_in} into rows {0, 1, 2}.
- On pix_valid=0:
  - Window, counters and state hold.
  - win_valid and frame_done deassert next cycle.
  - Bubbles are allowed anywhere, including mid-line.
- Position counters, advanced per accepted beat:
  - col_cnt increments and wraps IMG_WIDTH-1 -> 0.
  - On that wrap, row_cnt increments and wraps IMG_HEIGHT-1 -> 0.
  - Counters reflect the pixel just accepted.
- State machine:
  - FILL: row_cnt < 2. No windows are produced. Moves to ACTIVE when a beat with col_cnt=IMG_WIDTH-1 and row_cnt=1 is accepted.
  - ACTIVE: rows 2..IMG_HEIGHT-1. Returns to FILL when the beat at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
  - There is no idle state. The next frame starts immediately.
- Window validity, registered:
  - win_valid=1 the cycle after accepting a beat with state=ACTIVE and col_cnt >= 2.
  - Columns 0 and 1 of each line produce no window, because the window still straddles the previous line.
  - win_col = col_cnt-1 and win_row = row_cnt-1 of that beat.
- Latency: 1 cycle from the completing beat to win_valid/win_data.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame. No border padding.
- frame_done: asserted together with win_valid for the beat at (IMG_HEIGHT-1, IMG_WIDTH-1), center (IMG_HEIGHT-2, IMG_WIDTH-2). Never asserted otherwise.
- Back-to-back frames with no gap: the first beat after frame_done is pixel (0,0) of the new frame. The new frame produces no windows for its first two lines.
- Widths and arithmetic: counters are unsigned and sized by $clog2. Non-power-of-two dimensions wrap by explicit compare, never by overflow.

Decomposition:
- Shared package img_pipe_pkg holds:
  - state enum {FILL, ACTIVE};
  - WIN_TAPS=9 and WIN_DIM=3;
  - an index function win_idx(r,c)=3r+c, reused by downstream kernels.
- One natural sub-module, raster_pos_counter: col/row counters, wrap flags, end-of-line and end-of-frame strobes. It is reusable by the line-buffer write side.
- Window shift registers and the state machine stay in window_3x3_gen.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=8; stimulus pixel = 16*row+col, fed on row2_in with row1_in/row0_in = same column from lines -1/-2, or 0 when those lines are absent):
- Continuous frame -> first win_valid the cycle after pixel (2,2). win_data rows = {00,01,02},{10,11,12},{20,21,22}, win_row=1, win_col=1. Exactly 4 windows per frame, centers (1,1),(1,2),(2,1),(2,2).
- Line boundary -> no win_valid after beats (3,0) and (3,1). Next window after (3,2): center (2,1), top row {10,11,12}.
- Stall: pix_valid low for 5 cycles between (2,2) and (2,3) -> win_valid high once, then low for the stall. Window for (2,3) = {01,02,03},{11,12,13},{21,22,23}.
- End of frame -> frame_done and win_valid high together for center (2,2) only. A second back-to-back frame repeats the identical 4-window sequence.
- Reset mid-frame: rst_n=0 for one edge after pixel (2,1) -> all outputs 0. Replaying from (0,0) produces the full 4-window sequence with no stale window.
- Minimum size IMG_WIDTH=3, IMG_HEIGHT=3 -> exactly one window, center (1,1), with frame_done=1.

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// ============================================================================
// img_pipe_pkg : shared image-pipeline types, window geometry and tap index
// Rev 1.0
// ============================================================================
`default_nettype none

package img_pipe_pkg;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    ACTIVE = 1'b1
  } win_state_e;

  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  function automatic int win_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_3x3_gen_if.sv
// ============================================================================
// window_3x3_gen_if : column-beat input and 3x3 window output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface window_3x3_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  import img_pipe_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                           pix_valid;
  logic [DATA_WIDTH-1:0]          row2_in;
  logic [DATA_WIDTH-1:0]          row1_in;
  logic [DATA_WIDTH-1:0]          row0_in;
  logic [WIN_TAPS*DATA_WIDTH-1:0] win_data;
  logic                           win_valid;
  logic [CW-1:0]                  win_col;
  logic [RW-1:0]                  win_row;
  logic                           frame_done;

  modport master (
    output pix_valid, row2_in, row1_in, row0_in,
    input  win_data, win_valid, win_col, win_row, frame_done
  );

  modport slave (
    input  pix_valid, row2_in, row1_in, row0_in,
    output win_data, win_valid, win_col, win_row, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/window_3x3_gen_raster_pos_counter.sv
// ============================================================================
// raster_pos_counter : column/row position of the next accepted beat
// Rev 1.0
// ============================================================================
`default_nettype none

module raster_pos_counter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          eol_o,
  output logic          eof_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, row_last;

  // Non-power-of-two dimensions wrap on an explicit compare, never on overflow
  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    eol_o = adv_i && col_last;
    eof_o = eol_o && row_last;
    if (adv_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

`default_nettype wire

// File: rtl/window_3x3_gen.sv
// ============================================================================
// window_3x3_gen : 3x3 sliding window over aligned line-buffer column beats
// Rev 1.0
// ============================================================================
`default_nettype none

module window_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  window_3x3_gen_if.slave  bus
);
  import img_pipe_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          eol, eof;

  win_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] win_q [WIN_DIM][WIN_DIM];
  logic                  win_valid_q, win_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [CW-1:0]         win_col_q;
  logic [RW-1:0]         win_row_q;
  logic [DATA_WIDTH-1:0] col_in [WIN_DIM];

  raster_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (bus.pix_valid),
    .col_o (col),
    .row_o (row),
    .eol_o (eol),
    .eof_o (eof)
  );

  assign col_in[0] = bus.row0_in;
  assign col_in[1] = bus.row1_in;
  assign col_in[2] = bus.row2_in;

  always_comb begin
    state_d      = state_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      FILL: begin
        if (eol && (row == RW'(1))) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Columns 0 and 1 still straddle the previous line
        win_valid_d  = bus.pix_valid && (col >= CW'(2));
        frame_done_d = eof;
        if (eof) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
    end else begin
      if (bus.pix_valid) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= col_in[r];
        end
      end
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (win_valid_d) begin
        win_col_q <= col - 1'b1;
        win_row_q <= row - 1'b1;
      end
    end
  end

  for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
    for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
      assign bus.win_data[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
// ============================================================================
// tb_window_3x3_gen : randomized frames checked against an image-array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus4 ();
  window_3x3_gen_if #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) bus3 ();

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int checks = 0;
  int errors = 0;
  int win_cnt;
  int fd_cnt;

  logic [DW-1:0] img  [H][W];
  logic [DW-1:0] img3 [3][3];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected window centred one row and one column behind pixel (r,c)
  function automatic logic [9*DW-1:0] exp_window(input int r, input int c);
    logic [9*DW-1:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
    return w;
  endfunction

  task automatic bubble4();
    bus4.pix_valid = 1'b0;
    bus4.row2_in   = DW'($urandom);
    bus4.row1_in   = DW'($urandom);
    bus4.row0_in   = DW'($urandom);
    @(posedge clk); #1;
    check_val("bubble_valid", 128'(bus4.win_valid), 128'(0));
    check_val("bubble_fd", 128'(bus4.frame_done), 128'(0));
  endtask

  task automatic beat4(input int r, input int c);
    bit win_exp;
    bus4.pix_valid = 1'b1;
    bus4.row2_in   = img[r][c];
    bus4.row1_in   = (r >= 1) ? img[r-1][c] : '0;
    bus4.row0_in   = (r >= 2) ? img[r-2][c] : '0;
    @(posedge clk); #1;
    win_exp = (r >= 2) && (c >= 2);
    if (bus4.win_valid) win_cnt++;
    if (bus4.frame_done) fd_cnt++;
    check_val("win_valid", 128'(bus4.win_valid), 128'(win_exp));
    check_val("frame_done", 128'(bus4.frame_done), 128'((r == H-1) && (c == W-1)));
    if (win_exp) begin
      check_val("win_data", 128'(bus4.win_data), 128'(exp_window(r, c)));
      check_val("win_col", 128'(bus4.win_col), 128'(c - 1));
      check_val("win_row", 128'(bus4.win_row), 128'(r - 1));
    end
  endtask

  task automatic fill_img(input bit pattern);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pattern ? DW'(16*r + c) : DW'($urandom);
  endtask

  task automatic run_frame4(input bit pattern, input bit stall);
    fill_img(pattern);
    win_cnt = 0;
    fd_cnt  = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!pattern && ($urandom_range(0, 3) == 0))
          repeat ($urandom_range(1, 2)) bubble4();
        beat4(r, c);
        if (stall && r == 2 && c == 2)
          repeat (5) bubble4();
      end
    end
    check_val("win_count", 128'(win_cnt), 128'((W-2)*(H-2)));
    check_val("fd_count", 128'(fd_cnt), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data4"},  128'(bus4.win_data),   128'(0));
    check_val({tag, "_valid4"}, 128'(bus4.win_valid),  128'(0));
    check_val({tag, "_col4"},   128'(bus4.win_col),    128'(0));
    check_val({tag, "_row4"},   128'(bus4.win_row),    128'(0));
    check_val({tag, "_fd4"},    128'(bus4.frame_done), 128'(0));
    check_val({tag, "_valid3"}, 128'(bus3.win_valid),  128'(0));
  endtask

  initial begin
    bus4.pix_valid = 1'b0;
    bus4.row2_in = '0; bus4.row1_in = '0; bus4.row0_in = '0;
    bus3.pix_valid = 1'b0;
    bus3.row2_in = '0; bus3.row1_in = '0; bus3.row0_in = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Pattern frame with a mid-line stall, then a gapless repeat
    run_frame4(1'b1, 1'b1);
    run_frame4(1'b1, 1'b0);

    for (int f = 0; f < 6; f++) run_frame4(1'b0, 1'b0);

    // Reset mid-frame after pixel (2,1), then replay a full frame
    fill_img(1'b1);
    win_cnt = 0;
    fd_cnt  = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 2) beat4(r, c);
    bus4.pix_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    run_frame4(1'b1, 1'b0);

    // Minimum frame size: two back-to-back 3x3 frames
    for (int f = 0; f < 2; f++) begin
      win_cnt = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          img3[r][c] = DW'($urandom);
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          bus3.pix_valid = 1'b1;
          bus3.row2_in   = img3[r][c];
          bus3.row1_in   = (r >= 1) ? img3[r-1][c] : '0;
          bus3.row0_in   = (r >= 2) ? img3[r-2][c] : '0;
          @(posedge clk); #1;
          if (bus3.win_valid) win_cnt++;
          check_val("min_valid", 128'(bus3.win_valid), 128'(r == 2 && c == 2));
          check_val("min_fd", 128'(bus3.frame_done), 128'(r == 2 && c == 2));
          if (r == 2 && c == 2) begin
            logic [9*DW-1:0] w3 = '0;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                w3[(3*i+j)*DW +: DW] = img3[i][j];
            check_val("min_data", 128'(bus3.win_data), 128'(w3));
            check_val("min_col", 128'(bus3.win_col), 128'(1));
            check_val("min_row", 128'(bus3.win_row), 128'(1));
          end
        end
      end
      check_val("min_count", 128'(win_cnt), 128'(1));
    end
    bus3.pix_valid = 1'b0;
    @(posedge clk); #1;
    check_val("min_tail_valid", 128'(bus3.win_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
